// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state encodings and the default
//               datapath widths that the register array also uses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  // Default widths, shared with the register array.
  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_ADDR_WIDTH = 5;

  // Operation encodings. Bit 1 distinguishes divide-class from
  // multiply-class operations; bit 0 selects which half of the accumulator
  // is returned.
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,  // product bits [W-1:0]
    OP_MULHU = 2'b01,  // product bits [2W-1:W]
    OP_DIVU  = 2'b10,  // quotient
    OP_REMU  = 2'b11   // remainder
  } op_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True for operations that use the restoring divider.
  function automatic logic op_is_div(input op_t op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // True for operations that return the upper half of the accumulator
  // (MULHU: high product word, REMU: remainder).
  function automatic logic op_sel_high(input op_t op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the shift-add multiplier or
//               the restoring divider.
//
//   Multiply : acc = {hi, lo}. If i_bit (current multiplier LSB) is set,
//              the multiplicand is added into hi; the (W+1)-bit sum and lo
//              are then shifted right by one.
//   Divide   : acc = {rem, quo}. The pair is shifted left by one with
//              i_bit (next dividend bit, MSB first) entering rem. The
//              divisor is trial-subtracted from the widened remainder; if
//              the result is non-negative it is kept and o_q_bit is 1,
//              otherwise the shifted remainder is restored. The quotient
//              LSB is left at 0 in o_acc and is merged by the caller.
//
// Ports       :
//   i_acc      in  2W  current accumulator
//   i_operand  in  W   multiplicand (multiply) or divisor (divide)
//   i_bit      in  1   multiplier LSB (multiply) or dividend MSB (divide)
//   i_is_div   in  1   selects the divide iteration
//   o_acc      out 2W  next accumulator
//   o_q_bit    out 1   quotient bit produced by a divide iteration
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0]   i_operand,
  input  logic                    i_bit,
  input  logic                    i_is_div,
  output logic [2*DATA_WIDTH-1:0] o_acc,
  output logic                    o_q_bit
);

  logic [DATA_WIDTH-1:0] w_hi;
  logic [DATA_WIDTH-1:0] w_lo;
  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [DATA_WIDTH:0]   w_rem_shift;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_diff_ok;

  assign w_hi = i_acc[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_lo = i_acc[DATA_WIDTH-1:0];

  // Multiply: the carry out of the add lands in the sum's top bit, which
  // becomes the accumulator MSB after the right shift.
  assign w_mul_sum = {1'b0, w_hi} + (i_bit ? {1'b0, i_operand} : '0);

  // Divide: the widened remainder is always below 2*divisor, so a
  // non-negative difference always fits back into W bits and bit W of the
  // difference acts as the sign.
  assign w_rem_shift = {w_hi, i_bit};
  assign w_diff      = w_rem_shift - {1'b0, i_operand};
  assign w_diff_ok   = ~w_diff[DATA_WIDTH];

  always_comb begin
    o_acc   = '0;
    o_q_bit = 1'b0;
    if (i_is_div) begin
      o_q_bit = w_diff_ok;
      o_acc   = {(w_diff_ok ? w_diff[DATA_WIDTH-1:0] : w_rem_shift[DATA_WIDTH-1:0]),
                 w_lo[DATA_WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_mul_sum, w_lo[DATA_WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle unsigned multiply/divide unit for the execute
//               stage. One bit per clock: shift-add multiply, restoring
//               divide. A request is accepted in IDLE, iterates DATA_WIDTH
//               times in CALC, and presents a one-cycle done /
//               write_word_enable pulse in DONE together with the result
//               and destination register address.
//
// Ports       :
//   clk               in  1   system clock, rising edge
//   rst_n             in  1   asynchronous active-low reset
//   start             in  1   request, sampled only in IDLE
//   op                in  2   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   operand_a         in  W   multiplicand / dividend
//   operand_b         in  W   multiplier / divisor
//   dest_addr         in  A   destination register
//   busy              out 1   state is not IDLE
//   done              out 1   one-cycle completion pulse
//   result            out W   registered result
//   result_addr       out A   registered destination
//   write_word_enable out 1   register-array word write, equals done
//
// Build option: MULDIV_FAST_ZERO_EN - when defined, a request with a zero
//               operand goes straight from IDLE to DONE with the result
//               that the full computation would produce.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH,
  parameter int ADDR_WIDTH = MD_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] result_addr,
  output logic                  write_word_enable
);

  localparam logic [CNT_WIDTH-1:0] C_ITERATIONS = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] C_LAST_ITER  = CNT_WIDTH'(1);

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_cnt;
  op_t                     r_op;
  logic [2*DATA_WIDTH-1:0] r_acc;
  // Operand added/subtracted each iteration: multiplicand or divisor.
  logic [DATA_WIDTH-1:0]   r_opnd;
  // Operand consumed one bit per iteration: multiplier (LSB first, shifted
  // right) or dividend (MSB first, shifted left).
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [ADDR_WIDTH-1:0]   r_dest;
  logic [DATA_WIDTH-1:0]   r_result;
  logic [ADDR_WIDTH-1:0]   r_result_addr;

  logic                    w_is_div;
  logic                    w_step_bit;
  logic [2*DATA_WIDTH-1:0] w_step_acc;
  logic                    w_q_bit;
  logic [2*DATA_WIDTH-1:0] w_acc_next;
  logic [DATA_WIDTH-1:0]   w_calc_result;

  assign w_is_div   = op_is_div(r_op);
  assign w_step_bit = w_is_div ? r_shift[DATA_WIDTH-1] : r_shift[0];

  muldiv_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .i_bit     (w_step_bit),
    .i_is_div  (w_is_div),
    .o_acc     (w_step_acc),
    .o_q_bit   (w_q_bit)
  );

  // The step leaves the quotient LSB clear; it is merged in here. For a
  // multiply w_q_bit is 0 so the step's LSB passes through unchanged.
  assign w_acc_next = {w_step_acc[2*DATA_WIDTH-1:1], w_step_acc[0] | w_q_bit};

  // Result of the final iteration, captured on the edge entering DONE.
  assign w_calc_result = op_sel_high(r_op) ? w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH]
                                           : w_acc_next[DATA_WIDTH-1:0];

`ifdef MULDIV_FAST_ZERO_EN
  logic                  w_zero_operand;
  logic [DATA_WIDTH-1:0] w_fast_result;

  // Closed-form result for a zero operand, matching the iterative datapath:
  // divide by zero yields an all-ones quotient and a remainder equal to the
  // dividend; every other zero-operand case yields 0.
  always_comb begin
    w_zero_operand = (operand_a == '0) || (operand_b == '0);
    w_fast_result  = '0;
    if ((op == OP_DIVU) && (operand_b == '0)) begin
      w_fast_result = '1;
    end else if ((op == OP_REMU) && (operand_b == '0)) begin
      w_fast_result = operand_a;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_op          <= OP_MUL;
      r_acc         <= '0;
      r_opnd        <= '0;
      r_shift       <= '0;
      r_dest        <= '0;
      r_result      <= '0;
      r_result_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op   <= op_t'(op);
            r_dest <= dest_addr;
            r_acc  <= '0;
            r_cnt  <= C_ITERATIONS;
            if (op[1]) begin
              r_opnd  <= operand_b;
              r_shift <= operand_a;
            end else begin
              r_opnd  <= operand_a;
              r_shift <= operand_b;
            end
`ifdef MULDIV_FAST_ZERO_EN
            if (w_zero_operand) begin
              r_result      <= w_fast_result;
              r_result_addr <= dest_addr;
              r_state       <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
`else
            r_state <= ST_CALC;
`endif
          end
        end

        ST_CALC: begin
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt - 1'b1;
          r_shift <= w_is_div ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                              : {1'b0, r_shift[DATA_WIDTH-1:1]};
          // Counter reaches 0 with this iteration: it was the last one.
          if (r_cnt == C_LAST_ITER) begin
            r_result      <= w_calc_result;
            r_result_addr <= r_dest;
            r_state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the state register directly, so they change only
  // on clock edges (or reset) like the other registered outputs.
  assign busy              = (r_state != ST_IDLE);
  assign done              = (r_state == ST_DONE);
  assign write_word_enable = (r_state == ST_DONE);
  assign result            = r_result;
  assign result_addr       = r_result_addr;

endmodule

`default_nettype wire
